// File: rtl/mdlu_sequencer_if.sv
// Command/result bundle between the decode stage (master) and the MDLU sequencer (slave).
interface mdlu_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             readHiLo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output start, op, srcA, srcB, readHiLo,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op, srcA, srcB, readHiLo,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/mdlu_sequencer.sv
// Multi-cycle signed multiply / restoring divide sequencer owning HI/LO.
// Magnitudes are iterated on one shared adder; signs are applied in the FIX state.
module mdlu_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input logic               clock,
  input logic               resetN,
  mdlu_sequencer_if.slave   bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;
  typedef enum logic [1:0] {OpMult = 2'd0, OpDiv = 2'd1, OpZero = 2'd2, OpRsvd = 2'd3} op_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   src_a_q, src_a_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     add_a, add_b;
  logic               add_cin;
  logic [WIDTH+1:0]   sum;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign mag_a = bus.srcA[WIDTH-1] ? -bus.srcA : bus.srcA;
  assign mag_b = bus.srcB[WIDTH-1] ? -bus.srcB : bus.srcB;

  // Shared adder: MULT adds multiplicand to the upper half; DIV trial-subtracts the divisor
  // from the shifted remainder, sum[WIDTH+1] set means no borrow.
  always_comb begin
    if (is_div_q) begin
      add_a   = acc_q[2*WIDTH-1:WIDTH-1];
      add_b   = ~{1'b0, mcand_q};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      add_b   = {1'b0, mcand_q};
      add_cin = 1'b0;
    end
    sum = (WIDTH+2)'(add_a) + (WIDTH+2)'(add_b) + (WIDTH+2)'(add_cin);
  end

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    src_a_d    = src_a_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          case (op_e'(bus.op))
            OpMult, OpDiv: begin
              is_div_d   = (op_e'(bus.op) == OpDiv);
              acc_d      = {{WIDTH{1'b0}}, is_div_d ? mag_a : mag_b};
              mcand_d    = is_div_d ? mag_b : mag_a;
              src_a_d    = bus.srcA;
              neg_d      = bus.srcA[WIDTH-1] ^ bus.srcB[WIDTH-1];
              rem_neg_d  = bus.srcA[WIDTH-1];
              div_zero_d = (bus.srcB == '0);
              cnt_d      = '0;
              state_d    = StCalc;
            end
            OpZero: begin
              hi_d   = '0;
              lo_d   = '0;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      StCalc: begin
        if (is_div_q) begin
          if (sum[WIDTH+1]) acc_d = {sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else              acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
          if (acc_q[0]) acc_d = {sum[WIDTH:0], acc_q[WIDTH-1:1]};
          else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
      end
      StFix: begin
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (div_zero_q) begin
          hi_d = src_a_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      src_a_q    <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      src_a_q    <= src_a_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.done  = done_q;
  assign bus.busy  = (state_q != StIdle);
  assign bus.stall = bus.busy & (bus.readHiLo | bus.start);

endmodule

// File: tb/tb_mdlu_sequencer.sv
// Directed bench for mdlu_sequencer: latency, signed results, divide corner cases, stall, reset.
module tb_mdlu_sequencer;

  localparam int unsigned WIDTH = 32;
  localparam logic [1:0] OpMult = 2'd0;
  localparam logic [1:0] OpDiv  = 2'd1;
  localparam logic [1:0] OpZero = 2'd2;
  localparam logic [1:0] OpRsvd = 2'd3;

  logic clock;
  logic resetN;
  int   tests_run;
  int   tests_failed;

  mdlu_sequencer_if #(.WIDTH(WIDTH)) bus ();

  mdlu_sequencer #(.WIDTH(WIDTH)) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issues one command and waits for completion; returns in the done cycle.
  task automatic run_op(input string tag, input logic [1:0] op_v, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int n;
    int moved;
    logic [31:0] pre_hi, pre_lo;
    pre_hi = bus.hi;
    pre_lo = bus.lo;
    bus.start = 1'b1;
    bus.op    = op_v;
    bus.srcA  = a;
    bus.srcB  = b;
    step();
    bus.start = 1'b0;
    n = 0;
    moved = 0;
    while (bus.busy && n < 100) begin
      if (bus.hi !== pre_hi || bus.lo !== pre_lo || bus.done) moved++;
      n++;
      step();
    end
    check_eq({tag, "_latency"}, 64'(n), 64'd33);
    check_eq({tag, "_hold"}, 64'(moved), 64'd0);
    check_eq({tag, "_done"}, 64'(bus.done), 64'd1);
    check_eq({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    check_eq({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
  endtask

  initial begin
    int n;
    int bad;
    int done_seen;
    logic [31:0] pre_hi, pre_lo;
    tests_run    = 0;
    tests_failed = 0;
    bus.start    = 1'b0;
    bus.op       = OpMult;
    bus.srcA     = '0;
    bus.srcB     = '0;
    bus.readHiLo = 1'b0;
    resetN       = 1'b0;
    step();
    step();
    check_eq("rst_hi", 64'(bus.hi), 64'd0);
    check_eq("rst_lo", 64'(bus.lo), 64'd0);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    resetN = 1'b1;
    step();

    run_op("mul_7_m3", OpMult, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    step();
    check_eq("single_done", 64'(bus.done), 64'd0);

    // Reserved op is ignored
    bus.start = 1'b1;
    bus.op    = OpRsvd;
    step();
    bus.start = 1'b0;
    check_eq("rsvd_done", 64'(bus.done), 64'd0);
    check_eq("rsvd_busy", 64'(bus.busy), 64'd0);
    check_eq("rsvd_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    check_eq("rsvd_lo", 64'(bus.lo), 64'hFFFF_FFEB);

    // ZERO clears on the sampling edge, no busy, stall stays low
    bus.start = 1'b1;
    bus.op    = OpZero;
    #1;
    check_eq("zero_stall", 64'(bus.stall), 64'd0);
    step();
    bus.start = 1'b0;
    check_eq("zero_hi", 64'(bus.hi), 64'd0);
    check_eq("zero_lo", 64'(bus.lo), 64'd0);
    check_eq("zero_done", 64'(bus.done), 64'd1);
    check_eq("zero_busy", 64'(bus.busy), 64'd0);
    step();
    check_eq("zero_done_clr", 64'(bus.done), 64'd0);

    // Back-to-back chain: each run_op starts in the previous done cycle
    run_op("mul_min_min", OpMult, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    run_op("div_m7_2", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_5_0", OpDiv, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_op("div_min_m1", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    step();
    check_eq("chain_done_clr", 64'(bus.done), 64'd0);

    // Stall: readHiLo from cycle 5, ignored re-start at cycle 10
    pre_hi = bus.hi;
    pre_lo = bus.lo;
    bus.start = 1'b1;
    bus.op    = OpMult;
    bus.srcA  = 32'h0001_2345;
    bus.srcB  = 32'h0001_0000;
    step();
    bus.start = 1'b0;
    n   = 0;
    bad = 0;
    while (bus.busy && n < 100) begin
      n++;
      if (n == 5) bus.readHiLo = 1'b1;
      if (n == 10) begin
        bus.start = 1'b1;
        bus.op    = OpDiv;
        bus.srcB  = 32'd3;
      end
      if (n == 11) bus.start = 1'b0;
      #1;
      if (n == 5) check_eq("stall_read", 64'(bus.stall), 64'd1);
      if (n == 10) check_eq("stall_start", 64'(bus.stall), 64'd1);
      if (n >= 5 && bus.stall !== 1'b1) bad++;
      if (bus.hi !== pre_hi || bus.lo !== pre_lo) bad++;
      step();
    end
    check_eq("stall_hold", 64'(bad), 64'd0);
    check_eq("stall_latency", 64'(n), 64'd33);
    #1;
    check_eq("stall_done", 64'(bus.done), 64'd1);
    check_eq("stall_release", 64'(bus.stall), 64'd0);
    check_eq("stall_hi", 64'(bus.hi), 64'h1);
    check_eq("stall_lo", 64'(bus.lo), 64'h2345_0000);
    bus.readHiLo = 1'b0;
    step();

    // Reset in the middle of a DIV aborts it
    bus.start = 1'b1;
    bus.op    = OpDiv;
    bus.srcA  = 32'd100;
    bus.srcB  = 32'd7;
    step();
    bus.start = 1'b0;
    for (int i = 1; i < 10; i++) step();
    resetN = 1'b0;
    #1;
    check_eq("abort_hi", 64'(bus.hi), 64'd0);
    check_eq("abort_lo", 64'(bus.lo), 64'd0);
    check_eq("abort_busy", 64'(bus.busy), 64'd0);
    check_eq("abort_done", 64'(bus.done), 64'd0);
    step();
    resetN = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done || bus.busy) done_seen++;
      step();
    end
    check_eq("abort_quiet", 64'(done_seen), 64'd0);
    run_op("mul_3_4", OpMult, 32'd3, 32'd4, 32'd0, 32'd12);
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mdlu_sequencer.md
# mdlu_sequencer

Multi-cycle sequencer for the mult/div unit (MDLU) of the MIPS core. Accepts MULT, DIV and ZERO commands from the decode stage and runs a 32-iteration signed shift-add multiply or restoring divide on one shared adder. It owns the HI/LO registers read by MFHI/MFLO and drives a stall request that freezes the PC while an operation is in flight and the core either reads HI/LO or issues another MDLU command.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clock  in  1  core clock; all state changes on the rising edge.
- resetN  in  1  asynchronous, active-low reset.
- start  in  1  command strobe, sampled on the rising edge.
- op  in  2  command: 0 = MDLU_MULT, 1 = MDLU_DIV, 2 = MDLU_ZERO, 3 = reserved.
- srcA  in  WIDTH  rs value: multiplicand or dividend, two's complement.
- srcB  in  WIDTH  rt value: multiplier or divisor, two's complement.
- readHiLo  in  1  current instruction is MFHI or MFLO.
- hi  out  WIDTH  HI register: product upper half or remainder.
- lo  out  WIDTH  LO register: product lower half or quotient.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse; HI/LO were updated on the previous edge.
- stall  out  1  combinational: busy & (readHiLo | start).

## Operation
- States are IDLE, CALC and FIX.
- **IDLE**:
  - start with op=MULT or DIV: latch |srcA| and |srcB| as unsigned magnitudes, the result sign(s), op, and the divisor-zero flag. Clear the iteration counter and go to CALC.
  - start with op=ZERO: clear hi and lo on that edge, pulse done, stay in IDLE.
  - start with op=3: ignored; no state change and no done.
- **CALC**: one iteration per cycle for WIDTH cycles, then go to FIX.
  - MULT: if the multiplier LSB is 1, add the multiplicand to the upper half of a 2·WIDTH accumulator. Then shift the accumulator and multiplier right by 1.
  - DIV (restoring): shift the {remainder, quotient} pair left by 1. Trial-subtract the divisor from the remainder. If the result is non-negative, keep it and set the quotient LSB to 1.
- **FIX**: apply the sign correction, write hi/lo, pulse done, go to IDLE.
  - MULT: negate the 2·WIDTH product if sign(srcA) ≠ sign(srcB).
  - DIV: the quotient is negative if the operand signs differ. The remainder takes the sign of the dividend.
  - DIV by zero: hi = original srcA, lo = all ones. The iterations still run and the latency is unchanged.
  - DIV of 0x80000000 by 0xFFFFFFFF: lo = 0x80000000, hi = 0. This is the natural result of magnitude arithmetic; no special case is needed.
- start while busy=1 is ignored by the sequencer. The stall output holds the instruction until busy falls; the core re-presents start in the done cycle, which IDLE accepts.
- hi/lo keep their old values for the whole of CALC. They change only in FIX, or on a ZERO command.

## Timing
- Reset values (asynchronous, resetN=0): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Operand registers are cleared.
- Reset during CALC or FIX aborts the operation. No done pulse follows and hi/lo read 0.
- MULT/DIV latency:
  - start is sampled at edge E0.
  - busy=1 from after E0 through E33: exactly WIDTH+1 = 33 cycles (32 CALC + 1 FIX).
  - hi/lo are written at E33.
  - done=1 for the single cycle after E33, with busy=0 in that cycle.
- ZERO latency: hi/lo are cleared at E0, done=1 in the cycle after E0, and busy stays 0.
- done is never high for two consecutive cycles unless a new command was started in the done cycle.
- stall is combinational from busy, readHiLo and start, with no extra register. readHiLo in the done cycle gives stall=0 and sees the new value.
- Back-to-back: a start in the done cycle is accepted. The next result arrives 33 cycles later.

## Test plan
- MULT srcA=7, srcB=0xFFFFFFFD (−3) -> busy=1 for 33 cycles, then done=1 with hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0x00000000. Then DIV 0xFFFFFFF9 (−7) ÷ 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 5 ÷ 0 -> after 33 cycles hi=0x00000005, lo=0xFFFFFFFF. DIV 0x80000000 ÷ 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Stall: start a MULT, then drive readHiLo=1 at cycle 5 -> stall=1 through cycle 33 and hi/lo unchanged. In the done cycle, stall=0 and the product is visible. A second start at cycle 10 is ignored: no state change and stall=1.
- Reset: resetN=0 at cycle 10 of a DIV -> hi, lo, busy and done go to 0 immediately. No done pulse follows, and a new MULT 3×4 then gives lo=12, hi=0.
- ZERO after a MULT result -> hi=lo=0 one cycle later, with busy=0 throughout. op=3 with start=1 -> no done and registers unchanged.
